// File: rtl/led_fader.sv
// led_fader: per-channel brightness fader with PWM output.
// A captured target pattern steers each channel's level up to full scale or
// down to zero in fixed steps, once per prescaler tick. Levels are rendered
// as PWM on led_out, so pattern changes cross-fade instead of snapping.
// Handshake: load is a plain 1-cycle strobe with no ready; pattern_in is
// captured at any posedge where rst=1 and load=1, regardless of enable.
module led_fader #(
    parameter int WIDTH    = 8,
    parameter int PWM_BITS = 8,
    parameter int STEP     = 16,
    parameter int STEP_DIV = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] led_out,
    output logic             busy
);

    localparam int                 FS       = (1 << PWM_BITS) - 1;
    localparam int                 PS_W     = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] FS_V     = PWM_BITS'(FS);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(FS - 1);
    localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS:0]   FS_W     = (PWM_BITS + 1)'(FS);
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(STEP_DIV - 1);

    logic [WIDTH-1:0]    r_target;
    logic [PWM_BITS-1:0] r_level [WIDTH];
    logic [PS_W-1:0]     r_presc;
    logic [PWM_BITS-1:0] r_pwm_cnt;

    logic                w_tick;
    logic [WIDTH-1:0]    w_target_next;
    logic [PWM_BITS:0]   w_sum        [WIDTH];
    logic [PWM_BITS-1:0] w_level_next [WIDTH];
    logic                w_busy_next;

    // Tick and next target: a load in the same cycle as a tick only affects later ticks.
    always_comb begin
        w_tick        = enable && (r_presc == PS_LAST);
        w_target_next = load ? pattern_in : r_target;
    end

    // Next level per channel: saturating add toward FS, flooring subtract toward 0.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i]        = {1'b0, r_level[i]} + STEP_W;
            w_level_next[i] = r_level[i];
            if (w_tick) begin
                if (r_target[i]) begin
                    w_level_next[i] = (w_sum[i] > FS_W) ? FS_V : w_sum[i][PWM_BITS-1:0];
                end else begin
                    w_level_next[i] = ({1'b0, r_level[i]} < STEP_W) ? '0
                                    : (r_level[i] - STEP_W[PWM_BITS-1:0]);
                end
            end
        end
    end

    // Busy looks ahead at next-cycle levels and targets so it tracks them without lag.
    always_comb begin
        w_busy_next = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_level_next[i] != (w_target_next[i] ? FS_V : '0)) begin
                w_busy_next = 1'b1;
            end
        end
    end

    // Target capture and level update; reset discards any ramp in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_target <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_level[i] <= '0;
            end
        end else begin
            r_target <= w_target_next;
            for (int i = 0; i < WIDTH; i++) begin
                r_level[i] <= w_level_next[i];
            end
        end
    end

    // Tick prescaler: advances only while enabled, wraps after STEP_DIV counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (enable) begin
            r_presc <= (r_presc == PS_LAST) ? '0 : (r_presc + PS_W'(1));
        end
    end

    // PWM counter: free-runs over FS values so level FS is always on and 0 always off.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : (r_pwm_cnt + PWM_BITS'(1));
        end
    end

    // Registered outputs: PWM compare and busy flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            led_out <= '0;
            busy    <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                led_out[i] <= (r_level[i] > r_pwm_cnt);
            end
            busy <= w_busy_next;
        end
    end

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: table-driven vectors, directed fade sequences and randomized
// traffic, all checked against an arithmetic reference model of the fader.
module tb_led_fader;

    localparam int W    = 8;
    localparam int FS   = 255;
    localparam int STEP = 16;
    localparam int DIV  = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] pattern_in;
    logic         load;
    logic         enable;
    logic [W-1:0] led_out;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic cur_en = 1'b1;

    // reference model state
    int           m_level [W];
    logic [W-1:0] m_target;
    int           m_presc;
    int           m_pwm;
    logic [W-1:0] m_led;
    logic         m_busy;
    int           m_ticks = 0;

    led_fader #(.WIDTH(W), .PWM_BITS(8), .STEP(STEP), .STEP_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .pattern_in (pattern_in),
        .load       (load),
        .enable     (enable),
        .led_out    (led_out),
        .busy       (busy)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst        = 1'b0;
        load       = 1'b0;
        pattern_in = '0;
        enable     = 1'b1;
        m_target   = '0;
        m_presc    = 0;
        m_pwm      = 0;
        m_led      = '0;
        m_busy     = 1'b0;
        for (int i = 0; i < W; i++) m_level[i] = 0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of the specified behaviour, written as plain integer arithmetic.
    task automatic model_update(input logic r, input logic l, input logic [W-1:0] p, input logic e);
        bit tick;
        if (!r) begin
            for (int i = 0; i < W; i++) m_level[i] = 0;
            m_target = '0;
            m_presc  = 0;
            m_pwm    = 0;
            m_led    = '0;
            m_busy   = 1'b0;
        end else begin
            for (int i = 0; i < W; i++) m_led[i] = (m_level[i] > m_pwm);
            tick = e && (m_presc == DIV - 1);
            if (tick) begin
                m_ticks++;
                for (int i = 0; i < W; i++) begin
                    if (m_target[i]) m_level[i] = (m_level[i] + STEP > FS) ? FS : m_level[i] + STEP;
                    else             m_level[i] = (m_level[i] < STEP) ? 0 : m_level[i] - STEP;
                end
            end
            if (l) m_target = p;
            if (e) m_presc = (m_presc + 1) % DIV;
            m_pwm  = (m_pwm + 1) % FS;
            m_busy = 1'b0;
            for (int i = 0; i < W; i++)
                if (m_level[i] != (m_target[i] ? FS : 0)) m_busy = 1'b1;
        end
    endtask

    // driver: apply inputs on negedge, advance model on posedge, compare #1 later
    task automatic step(input logic r, input logic l, input logic [W-1:0] p, input logic e);
        int bad_ch;
        @(negedge clk);
        rst = r; load = l; pattern_in = p; enable = e;
        @(posedge clk);
        model_update(r, l, p, e);
        #1;
        check("model_led_out", int'(led_out), int'(m_led));
        check("model_busy", int'(busy), int'(m_busy));
        bad_ch = -1;
        for (int i = 0; i < W; i++)
            if (int'(dut.r_level[i]) != m_level[i] && bad_ch < 0) bad_ch = i;
        check("model_levels_first_bad_ch", bad_ch, -1);
    endtask

    task automatic step_idle();
        step(1'b1, 1'b0, '0, cur_en);
    endtask

    task automatic wait_ticks(input int n);
        int start;
        int cnt;
        start = m_ticks;
        cnt   = 0;
        while ((m_ticks - start) < n && cnt < n * DIV + 8) begin
            step_idle();
            cnt++;
        end
        check("wait_ticks_timeout", m_ticks - start, n);
    endtask

    task automatic count_led0(input int cycles, output int highs);
        highs = 0;
        for (int k = 0; k < cycles; k++) begin
            step_idle();
            if (led_out[0]) highs++;
        end
    endtask

    typedef struct {
        logic         r;
        logic         l;
        logic [W-1:0] p;
        logic [W-1:0] exp_led;
        logic         exp_busy;
        int           exp_lvl;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int n;
        int bound;
        // reset with load asserted, then load FF and watch the first tick
        tbl[0] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 0};
        tbl[2] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 0};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 0};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 0};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 16};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 16};

        for (int v = 0; v < 8; v++) begin
            step(tbl[v].r, tbl[v].l, tbl[v].p, 1'b1);
            check($sformatf("vec%0d_led", v), int'(led_out), int'(tbl[v].exp_led));
            check($sformatf("vec%0d_busy", v), int'(busy), int'(tbl[v].exp_busy));
            check($sformatf("vec%0d_level7", v), int'(dut.r_level[7]), tbl[v].exp_lvl);
            if (v == 2) check("reset_target_held", int'(dut.r_target), 0);
        end

        // ramp up to full scale with clamping at the last tick
        wait_ticks(14);
        check("up_level_240", int'(dut.r_level[0]), 240);
        check("up_busy_mid", int'(busy), 1);
        wait_ticks(1);
        for (int i = 0; i < W; i++) check("up_clamped_255", int'(dut.r_level[i]), 255);
        check("up_busy_settled", int'(busy), 0);
        n = 0;
        for (int k = 0; k < FS; k++) begin
            step_idle();
            if (led_out == 8'hFF) n++;
        end
        check("full_led_constant_on", n, FS);

        // ramp down to zero with floor
        step(1'b1, 1'b1, 8'h00, 1'b1);
        wait_ticks(1);
        check("down_level_239", int'(dut.r_level[3]), 239);
        wait_ticks(14);
        check("down_level_15", int'(dut.r_level[3]), 15);
        wait_ticks(1);
        check("down_floor_0", int'(dut.r_level[3]), 0);
        check("down_busy_settled", int'(busy), 0);
        n = 0;
        for (int k = 0; k < FS; k++) begin
            step_idle();
            if (led_out == 8'h00) n++;
        end
        check("zero_led_constant_off", n, FS);

        // re-loading the current target keeps busy low
        step(1'b1, 1'b1, 8'h00, 1'b1);
        check("reload_busy_low", int'(busy), 0);
        step_idle();
        check("reload_busy_low_next", int'(busy), 0);

        // reversal mid-ramp, duty measured with levels frozen
        step(1'b1, 1'b1, 8'h01, 1'b1);
        check("load01_busy_rises", int'(busy), 1);
        wait_ticks(5);
        check("rev_level_80", int'(dut.r_level[0]), 80);
        cur_en = 1'b0;
        count_led0(FS, n);
        check("duty_80", n, 80);
        cur_en = 1'b1;
        step(1'b1, 1'b1, 8'h00, 1'b1);
        wait_ticks(1);
        check("rev_level_64", int'(dut.r_level[0]), 64);
        wait_ticks(4);
        check("rev_settled_0", int'(dut.r_level[0]), 0);

        // enable freeze
        step(1'b1, 1'b1, 8'h01, 1'b1);
        wait_ticks(3);
        check("freeze_level_48", int'(dut.r_level[0]), 48);
        cur_en = 1'b0;
        for (int k = 0; k < 100; k++) step_idle();
        check("freeze_hold_48", int'(dut.r_level[0]), 48);
        count_led0(FS, n);
        check("duty_48", n, 48);
        cur_en = 1'b1;
        for (int k = 0; k < 3; k++) step_idle();
        check("resume_still_48", int'(dut.r_level[0]), 48);
        step_idle();
        check("resume_level_64", int'(dut.r_level[0]), 64);

        // load coinciding with a tick uses the old target
        step(1'b1, 1'b1, 8'h00, 1'b1);
        wait_ticks(4);
        check("pre_coincide_0", int'(dut.r_level[0]), 0);
        bound = 0;
        while (m_presc != DIV - 1 && bound < 2 * DIV) begin
            step_idle();
            bound++;
        end
        check("align_to_tick", m_presc, DIV - 1);
        step(1'b1, 1'b1, 8'h01, 1'b1);
        check("coincide_level_0", int'(dut.r_level[0]), 0);
        wait_ticks(1);
        check("coincide_next_16", int'(dut.r_level[0]), 16);

        // reset mid-ramp
        wait_ticks(2);
        check("pre_reset_48", int'(dut.r_level[0]), 48);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("midreset_led", int'(led_out), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_level", int'(dut.r_level[0]), 0);
        check("midreset_target", int'(dut.r_target), 0);
        step_idle();
        check("post_reset_busy", int'(busy), 0);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 59) != 0),
                 1'($urandom_range(0, 19) == 0),
                 8'($urandom),
                 1'($urandom_range(0, 7) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
